// File: rtl/inst_loader_pkg.sv
// Shared types for the boot-time instruction loader: FSM states, header count
// and the instruction-memory address/word types.
package inst_loader_pkg;

  localparam int IM_ADDR_W = 10;

  typedef logic [IM_ADDR_W-1:0] im_addr_t;
  typedef logic [31:0]          inst_t;
  typedef logic [15:0]          ld_count_t;

  typedef enum logic [2:0] {
    IDLE,
    HDR0,
    HDR1,
    BYTES,
    WRITE,
    DONE,
    ERR
  } loader_state_enum;

  // Byte lane that the idx-th byte of a word occupies.
  function automatic logic [1:0] lane_sel(input logic [1:0] idx, input bit little_endian);
    return little_endian ? idx : 2'd3 - idx;
  endfunction

endpackage

// File: rtl/inst_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// master = stream source / IM side, slave = the loader itself.
interface inst_loader_if #(
  parameter int ADDR_W = 10
);

  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              ld_we;
  logic [ADDR_W-1:0] ld_addr;
  logic [31:0]       ld_inst;

  modport master (
    output rx_valid,
    output rx_data,
    input  rx_ready,
    input  ld_we,
    input  ld_addr,
    input  ld_inst
  );

  modport slave (
    input  rx_valid,
    input  rx_data,
    output rx_ready,
    output ld_we,
    output ld_addr,
    output ld_inst
  );

endinterface

// File: rtl/inst_loader_byte_packer.sv
// Assembles four accepted bytes into one 32-bit instruction; word exposes the
// word including the byte being strobed so the caller can capture it on that edge.
module inst_loader_byte_packer
  import inst_loader_pkg::*;
#(
  parameter bit LITTLE_ENDIAN = 1'b1
) (
  input  logic       cpu_clk_50M,
  input  logic       cpu_rst_n,
  input  logic       clear,
  input  logic       byte_stb,
  input  logic [7:0] byte_data,
  output inst_t      word,
  output logic       word_full
);

  logic [1:0] cnt_q;
  inst_t      data_q;
  inst_t      word_d;
  logic [1:0] lane;

  assign lane = lane_sel(cnt_q, LITTLE_ENDIAN);

  // NOTE: every variable driven here gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    word_d = data_q;
    if (byte_stb) word_d[{lane, 3'b000} +: 8] = byte_data;
  end

  assign word      = word_d;
  assign word_full = byte_stb && (cnt_q == 2'd3);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      cnt_q  <= '0;
      data_q <= '0;
    end else if (clear) begin
      cnt_q  <= '0;
      data_q <= '0;
    end else if (byte_stb) begin
      cnt_q  <= cnt_q + 2'd1;
      data_q <= word_d;
    end
  end

endmodule

// File: rtl/inst_loader.sv
// Boot loader: parses a 16-bit big-endian word-count header, packs the following
// bytes into instructions, writes them to consecutive IM addresses, then releases the core.
module inst_loader
  import inst_loader_pkg::*;
#(
  parameter int IM_DEPTH      = 1024,
  parameter int ADDR_W        = IM_ADDR_W,
  parameter bit LITTLE_ENDIAN = 1'b1,
  parameter int TIMEOUT       = 65535
) (
  input  logic          cpu_clk_50M,
  input  logic          cpu_rst_n,
  input  logic          start,
  inst_loader_if.slave  bus,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          cpu_run
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);

  loader_state_enum  state_q;
  ld_count_t         count_q;
  ld_count_t         hdr_count;
  logic [ADDR_W-1:0] index_q;
  logic [TMO_W-1:0]  tmo_q;
  logic [ADDR_W-1:0] ld_addr_q;
  inst_t             ld_inst_q;
  inst_t             packed_word;
  logic              rx_ready;
  logic              accept;
  logic              word_full;
  logic              tmo_expire;
  logic              last_word;

  assign rx_ready   = state_q inside {HDR0, HDR1, BYTES};
  assign accept     = bus.rx_valid && rx_ready;
  assign hdr_count  = {count_q[15:8], bus.rx_data};
  assign tmo_expire = (tmo_q == TMO_W'(TIMEOUT - 1));
  assign last_word  = (16'(index_q) == count_q - 16'd1);

  inst_loader_byte_packer #(
    .LITTLE_ENDIAN (LITTLE_ENDIAN)
  ) u_packer (
    .cpu_clk_50M (cpu_clk_50M),
    .cpu_rst_n   (cpu_rst_n),
    .clear       (state_q != BYTES),
    .byte_stb    (accept && (state_q == BYTES)),
    .byte_data   (bus.rx_data),
    .word        (packed_word),
    .word_full   (word_full)
  );

  // NOTE: all loader state is small and control-relevant, so all of it is reset; a partial word never survives reset.
  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state_q   <= IDLE;
      count_q   <= '0;
      index_q   <= '0;
      tmo_q     <= '0;
      ld_addr_q <= '0;
      ld_inst_q <= '0;
    end else begin
      case (state_q)
        IDLE, DONE, ERR: begin
          if (start) begin
            state_q <= HDR0;
            tmo_q   <= '0;
          end
        end
        HDR0: begin
          if (accept) begin
            count_q[15:8] <= bus.rx_data;
            tmo_q         <= '0;
            state_q       <= HDR1;
          end else if (tmo_expire) begin
            state_q <= ERR;
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
        end
        HDR1: begin
          if (accept) begin
            count_q[7:0] <= bus.rx_data;
            tmo_q        <= '0;
            index_q      <= '0;
            if (hdr_count == 16'd0)                     state_q <= DONE;
            else if ({1'b0, hdr_count} > 17'(IM_DEPTH)) state_q <= ERR;
            else                                        state_q <= BYTES;
          end else if (tmo_expire) begin
            state_q <= ERR;
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
        end
        BYTES: begin
          if (accept) begin
            tmo_q <= '0;
            // Capture address and word on the completing byte so both are valid during WRITE.
            if (word_full) begin
              ld_addr_q <= index_q;
              ld_inst_q <= packed_word;
              state_q   <= WRITE;
            end
          end else if (tmo_expire) begin
            state_q <= ERR;
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
        end
        WRITE: begin
          tmo_q <= '0;
          if (last_word) begin
            state_q <= DONE;
          end else begin
            index_q <= index_q + ADDR_W'(1);
            state_q <= BYTES;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.rx_ready = rx_ready;
  assign bus.ld_we    = (state_q == WRITE);
  assign bus.ld_addr  = ld_addr_q;
  assign bus.ld_inst  = ld_inst_q;
  assign busy         = state_q inside {HDR0, HDR1, BYTES, WRITE};
  assign done         = (state_q == DONE);
  assign cpu_run      = (state_q == DONE);
  assign err          = (state_q == ERR);

endmodule
